// File: rtl/la_capture_reader.sv
// Reads rd_len samples from the capture RAM, starting at start_addr and wrapping modulo 2**ADDR_WIDTH.
// Latency: first m_valid two clocks after the start edge; then one sample per clock while m_ready=1.
// Backpressure: a 2-entry buffer absorbs the RAM read latency; reads stall so that nothing is dropped or read twice.
//
// Ports:
//   clk, rst_n             : clock (also the RAM read clock), async active-low reset
//   start/start_addr/rd_len: readout request (start ignored while busy)
//   ram_raddr/ram_ren/ram_dout : RAM read port, data valid the cycle after ram_ren
//   m_data/m_valid/m_ready : sample stream toward the host formatter
//   busy, done             : readout in progress / one-cycle completion pulse
//   m_last                 : only when LA_RD_LAST_EN is defined; marks the final sample
module la_capture_reader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   rd_len,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic                  ram_ren,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done
`ifdef LA_RD_LAST_EN
   ,
   output logic                  m_last
`endif
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   remain_q, remain_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  done_q, done_d;

   logic       accept;
   logic       issue;
   logic       final_head;
   logic [2:0] occ_after;

   // Head of the buffer is accepted this cycle.
   assign accept = (cnt_q != 2'd0) && m_ready;

   // Occupancy counts the sample leaving this cycle as gone; this is what
   // allows one read per clock when the consumer never stalls, while still
   // bounding buffered + in-flight samples to two after every edge.
   assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, accept};

   assign issue = (state_q == READ) && (remain_q != '0) && (occ_after < 3'd2);

   // In DRAIN with nothing in flight, a single buffered sample is the last one.
   assign final_head = (state_q == DRAIN) && !inflight_q && (cnt_q == 2'd1);

   assign ram_ren   = issue;
   assign ram_raddr = ptr_q;
   assign m_data    = buf0_q;
   assign m_valid   = (cnt_q != 2'd0);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
`ifdef LA_RD_LAST_EN
   assign m_last    = final_head;
`endif

   // Control FSM: next state, pointer and counters.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      remain_d   = remain_q;
      inflight_d = issue;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (rd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  remain_d = rd_len;
                  ptr_d    = start_addr;
                  state_d  = READ;
               end
            end
         end
         READ: begin
            if (issue) begin
               ptr_d    = ptr_q + ADDR_WIDTH'(1);
               remain_d = remain_q - (ADDR_WIDTH + 1)'(1);
               if (remain_q == (ADDR_WIDTH + 1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (final_head && accept) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Two-entry buffer: buf0 is the head presented on m_data.
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      cnt_d  = cnt_q;
      case ({inflight_q, accept})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               buf0_d = ram_dout;
            end else begin
               buf1_d = ram_dout;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // Capture and accept together: occupancy unchanged, order kept.
            if (cnt_q == 2'd1) begin
               buf0_d = ram_dout;
            end else begin
               buf0_d = buf1_q;
               buf1_d = ram_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         cnt_q      <= 2'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         remain_q   <= remain_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_la_capture_reader.sv
// Bench for la_capture_reader: behavioural RAM, queue-based reference model
// sampled on the falling edge, directed scenarios plus randomized readouts.
module tb_la_capture_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] start_addr = '0;
   logic [12:0] rd_len = '0;
   logic [11:0] ram_raddr;
   logic        ram_ren;
   logic [7:0]  ram_dout = '0;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        busy;
   logic        done;
`ifdef LA_RD_LAST_EN
   logic        m_last;
`endif

   la_capture_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .rd_len     (rd_len),
      .ram_raddr  (ram_raddr),
      .ram_ren    (ram_ren),
      .ram_dout   (ram_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy),
      .done       (done)
`ifdef LA_RD_LAST_EN
      ,
      .m_last     (m_last)
`endif
   );

   always #5 clk = ~clk;

   // Capture RAM: registered read, output held when not enabled.
   logic [7:0] mem [4096];
   always @(posedge clk) if (ram_ren) ram_dout <= mem[ram_raddr];

   int n_cmp = 0;
   int n_fail = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [7:0]  mq[$];
   bit          mdl_busy = 0;
   bit          mdl_done = 0;
   int          mdl_len = 0;
   int          mdl_issued = 0;
   int          mdl_acc = 0;
   logic [11:0] mdl_addr = '0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          first_valid_cyc = -1;
   int          last_done_cyc = -1;
   int          acc_cyc_log[$];
   logic [7:0]  acc_dat_log[$];
   logic [11:0] addr_log[$];
   bit          prev_stall = 0;
   logic [7:0]  prev_data = '0;
   bit          wb;
   logic [11:0] ea, ta;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         mq.delete();
         mdl_busy = 0; mdl_done = 0; mdl_issued = 0; mdl_acc = 0;
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_valid", m_valid, 0);
         chk("rst_ren", ram_ren, 0);
         prev_stall = 0;
      end else begin
         wb = mdl_busy;
         chk("busy", busy, mdl_busy);
         chk("done", done, mdl_done);
         if (done) last_done_cyc = cyc;
         if (m_valid) begin
            if (mq.size() == 0) chk("valid_when_empty", m_valid, 0);
            else chk("data", m_data, mq[0]);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
         end
`ifdef LA_RD_LAST_EN
         chk("last", m_last, (m_valid && mq.size() == 1) ? 1 : 0);
`endif
         if (ram_ren) begin
            chk("ren_while_idle", ram_ren, mdl_busy);
            ea = mdl_addr + mdl_issued[11:0];
            chk("raddr", ram_raddr, ea);
            addr_log.push_back(ram_raddr);
            mdl_issued++;
            chk("issue_count", (mdl_issued <= mdl_len) ? 1 : 0, 1);
         end
         mdl_done = 0;
         if (m_valid && m_ready && mq.size() > 0) begin
            acc_cyc_log.push_back(cyc);
            acc_dat_log.push_back(m_data);
            void'(mq.pop_front());
            mdl_acc++;
            if (mq.size() == 0 && wb) begin
               mdl_done = 1;
               mdl_busy = 0;
            end
         end
         if (wb) chk("outstanding", ((mdl_issued - mdl_acc) <= 2) ? 1 : 0, 1);
         if (start && !wb) begin
            start_cyc = cyc;
            first_valid_cyc = -1;
            if (rd_len == 0) begin
               mdl_done = 1;
            end else begin
               mdl_busy = 1;
               mdl_len = int'(rd_len);
               mdl_addr = start_addr;
               mdl_issued = 0;
               mdl_acc = 0;
               for (int i = 0; i < int'(rd_len); i++) begin
                  ta = start_addr + 12'(i);
                  mq.push_back(mem[ta]);
               end
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data = m_data;
      end
   end

   // ---------------- m_ready driver ----------------
   int ready_mode = 0;
   bit rel = 0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: m_ready = 1'b1;
         1: m_ready = 1'($urandom_range(0, 1));
         2: m_ready = 1'b0;
         default: m_ready = (mdl_acc < 2) || rel;
      endcase
   end

   // ---------------- stimulus ----------------
   task automatic do_start(input logic [11:0] a, input logic [12:0] l);
      @(posedge clk); #1;
      start = 1'b1; start_addr = a; rd_len = l;
      @(posedge clk); #1;
      start = 1'b0; start_addr = 12'($urandom); rd_len = 13'($urandom);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      @(negedge clk);
      while ((mdl_busy || mdl_done || busy || done) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, (n < budget) ? 1 : 0, 1);
      @(negedge clk);
   endtask

   int base, abase, bad, n;
   int hits [4096];
   logic [11:0] wrap_addr [4];
   logic [7:0]  wrap_dat [4];
   logic [12:0] rl;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
      wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF; wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;
      wrap_dat[0] = 8'hFE; wrap_dat[1] = 8'hFF; wrap_dat[2] = 8'h00; wrap_dat[3] = 8'h01;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      ready_mode = 0;
      repeat (2) @(posedge clk);

      // Zero length: done one cycle after start, no reads, no data.
      abase = addr_log.size();
      do_start(12'h010, 13'd0);
      wait_idle(20, "zero_timeout");
      chk("zero_done_latency", last_done_cyc - start_cyc, 1);
      chk("zero_no_valid", first_valid_cyc, -1);
      chk("zero_no_reads", addr_log.size() - abase, 0);

      // Full speed: 05..08 on consecutive cycles; start seen at falling edge S,
      // sampled on the next rising edge, m_valid two edges later (edge S+3).
      base = acc_dat_log.size();
      do_start(12'h005, 13'd4);
      wait_idle(50, "fs_timeout");
      chk("fs_count", acc_dat_log.size() - base, 4);
      if (acc_dat_log.size() - base == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("fs_data", acc_dat_log[base + i], 8'h05 + 8'(i));
            chk("fs_cycle", acc_cyc_log[base + i] - start_cyc, 3 + i);
         end
      end
      chk("fs_first_valid", first_valid_cyc - start_cyc, 3);
      chk("fs_done", last_done_cyc - start_cyc, 7);

      // Wrap around the top of the buffer.
      base = acc_dat_log.size();
      abase = addr_log.size();
      do_start(12'hFFE, 13'd4);
      wait_idle(50, "wrap_timeout");
      chk("wrap_reads", addr_log.size() - abase, 4);
      chk("wrap_count", acc_dat_log.size() - base, 4);
      if (addr_log.size() - abase == 4 && acc_dat_log.size() - base == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", addr_log[abase + i], wrap_addr[i]);
            chk("wrap_data", acc_dat_log[base + i], wrap_dat[i]);
         end
      end

      // Full depth: every location read exactly once.
      base = acc_dat_log.size();
      abase = addr_log.size();
      do_start(12'($urandom), 13'd4096);
      wait_idle(6000, "full_timeout");
      chk("full_count", acc_dat_log.size() - base, 4096);
      for (int i = 0; i < 4096; i++) hits[i] = 0;
      for (int i = abase; i < addr_log.size(); i++) hits[addr_log[i]]++;
      bad = 0;
      for (int i = 0; i < 4096; i++) if (hits[i] != 1) bad++;
      chk("full_each_once", bad, 0);

      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

      // Back-pressure: random ready with a 10-cycle hold low.
      base = acc_dat_log.size();
      ready_mode = 1;
      do_start(12'($urandom), 13'd8);
      repeat (3) @(posedge clk);
      ready_mode = 2;
      repeat (10) @(posedge clk);
      ready_mode = 1;
      wait_idle(200, "bp_timeout");
      chk("bp_count", acc_dat_log.size() - base, 8);
      ready_mode = 0;

      // Reset mid-readout, then a clean 2-sample readout.
      base = acc_dat_log.size();
      do_start(12'($urandom), 13'd16);
      n = 0;
      while (acc_dat_log.size() - base < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_wait", (n < 100) ? 1 : 0, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ren", ram_ren, 0);
      chk("arst_raddr", ram_raddr, 0);
      chk("arst_valid", m_valid, 0);
      chk("arst_data", m_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      base = acc_dat_log.size();
      do_start(12'($urandom), 13'd2);
      wait_idle(50, "restart_timeout");
      chk("restart_count", acc_dat_log.size() - base, 2);

      // A start while busy must be ignored.
      base = acc_dat_log.size();
      do_start(12'h123, 13'd16);
      repeat (4) @(posedge clk);
      do_start(12'h800, 13'd5);
      wait_idle(100, "busy_start_timeout");
      chk("busy_start_count", acc_dat_log.size() - base, 16);

      // Randomized readouts.
      for (int k = 0; k < 12; k++) begin
         ready_mode = (k % 3 == 0) ? 0 : 1;
         rl = ($urandom_range(0, 7) == 0) ? 13'd0 : 13'($urandom_range(1, 40));
         base = acc_dat_log.size();
         do_start(12'($urandom), rl);
         wait_idle(500, "rand_timeout");
         chk("rand_count", acc_dat_log.size() - base, int'(rl));
      end
      ready_mode = 0;

`ifdef LA_RD_LAST_EN
      // m_last held through a stall on the final sample.
      rel = 0;
      ready_mode = 3;
      base = acc_dat_log.size();
      do_start(12'($urandom), 13'd3);
      n = 0;
      while (!(m_valid && mdl_acc == 2) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("last_wait", (n < 30) ? 1 : 0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("last_stall_last", m_last, 1);
         chk("last_stall_valid", m_valid, 1);
      end
      rel = 1;
      wait_idle(50, "last_timeout");
      chk("last_count", acc_dat_log.size() - base, 3);
      ready_mode = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
